// File: rtl/mix_columns_seq.sv
// mix_columns_seq: handshaked AES MixColumns / InvMixColumns engine on a
// 128-bit state, transforming COLS columns per RUN cycle.
`default_nettype none

module mix_columns_seq #(
    parameter int COLS   = 1,
    parameter bit INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic         i_inv,
    input  logic [127:0] i_state_in,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_state_out,
    output logic         o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [2:0] C_STEP = 3'(COLS);

    generate
        if (!(COLS == 1 || COLS == 2 || COLS == 4)) begin : g_bad_cols
            $error("mix_columns_seq: COLS must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] r  [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            // Coefficients 0e/0b/0d/09 expressed as sums of x, 2x, 4x, 8x.
            if (INV_EN && inv) begin
                r[i] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            end else begin
                r[i] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
            end
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [1:0]   r_col_idx;
    logic [127:0] r_work;
    logic         r_inv;
    logic [127:0] w_work_next;
    logic [31:0]  w_cols      [4];
    logic [31:0]  w_cols_next [4];
    logic [1:0]   w_idx       [COLS];
    logic [31:0]  w_mixed     [COLS];
    logic         w_accept;
    logic         w_last;

    assign w_accept = i_in_valid & o_in_ready;
    assign w_last   = ({1'b0, r_col_idx} + C_STEP) == 3'd4;

    generate
        for (genvar c = 0; c < 4; c++) begin : g_cols
            assign w_cols[c]                   = r_work[127-32*c -: 32];
            assign w_work_next[127-32*c -: 32] = w_cols_next[c];
        end
        for (genvar g = 0; g < COLS; g++) begin : g_mix
            assign w_idx[g]   = r_col_idx + 2'(g);
            assign w_mixed[g] = mix_col(w_cols[w_idx[g]], r_inv);
        end
    endgenerate

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_cols_next[c] = w_cols[c];
            for (int j = 0; j < COLS; j++) begin
                if (w_idx[j] == 2'(c)) begin
                    w_cols_next[c] = w_mixed[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  if (i_out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == S_IDLE);
        o_out_valid = (r_state == S_DONE);
        o_busy      = (r_state == S_RUN) || (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work    <= 128'h0;
            r_inv     <= 1'b0;
            r_col_idx <= 2'd0;
        end else if (w_accept) begin
            r_work    <= i_state_in;
            r_inv     <= i_inv & INV_EN;
            r_col_idx <= 2'd0;
        end else if (r_state == S_RUN) begin
            r_work    <= w_work_next;
            r_col_idx <= r_col_idx + C_STEP[1:0];
        end
    end

    assign o_state_out = r_work;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed checks of mix_columns_seq across COLS 1/2/4
// and an INV_EN=0 build, all sharing one clock and reset.
`default_nettype none

module tb_mix_columns_seq;

    localparam logic [127:0] C_PLAIN = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] C_MIXED = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] C_FP_IN = 128'hc6c6c6c6_01010101_db135345_f20a225c;
    localparam logic [127:0] C_FP_OUT = 128'hc6c6c6c6_01010101_8e4da1bc_9fdc589d;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [4];
    logic         inv       [4];
    logic         out_ready [4];
    logic [127:0] state_in  [4];
    logic         in_ready  [4];
    logic         out_valid [4];
    logic         busy      [4];
    logic [127:0] state_out [4];

    int n_cmp;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mix_columns_seq #(.COLS(1), .INV_EN(1'b1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_inv(inv[0]), .i_state_in(state_in[0]), .o_out_valid(out_valid[0]),
        .i_out_ready(out_ready[0]), .o_state_out(state_out[0]), .o_busy(busy[0]));

    mix_columns_seq #(.COLS(2), .INV_EN(1'b1)) u_c2 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_inv(inv[1]), .i_state_in(state_in[1]), .o_out_valid(out_valid[1]),
        .i_out_ready(out_ready[1]), .o_state_out(state_out[1]), .o_busy(busy[1]));

    mix_columns_seq #(.COLS(4), .INV_EN(1'b1)) u_c4 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
        .i_inv(inv[2]), .i_state_in(state_in[2]), .o_out_valid(out_valid[2]),
        .i_out_ready(out_ready[2]), .o_state_out(state_out[2]), .o_busy(busy[2]));

    mix_columns_seq #(.COLS(1), .INV_EN(1'b0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[3]), .o_in_ready(in_ready[3]),
        .i_inv(inv[3]), .i_state_in(state_in[3]), .o_out_valid(out_valid[3]),
        .i_out_ready(out_ready[3]), .o_state_out(state_out[3]), .o_busy(busy[3]));

    // Offers one block to DUT d, scrambles its inputs after accept, returns
    // the result and the number of edges from accept to out_valid.
    task automatic run_block(input int d, input logic [127:0] data, input logic iv,
                             output logic [127:0] res, output int lat);
        int guard;
        guard       = 0;
        in_valid[d] = 1'b1;
        state_in[d] = data;
        inv[d]      = iv;
        while (!in_ready[d] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (in_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait dut%0d: in_ready=%b required 1", d, in_ready[d]);
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        state_in[d] = ~data;
        inv[d]      = ~iv;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[d] && lat < 20);
        n_cmp++;
        if (out_valid[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL out_valid_wait dut%0d: out_valid=%b required 1", d, out_valid[d]);
        end
        res          = state_out[d];
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0
                || state_out[d] !== 128'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: rdy=%b vld=%b busy=%b out=%h required 1 0 0 0",
                         d, in_ready[d], out_valid[d], busy[d], state_out[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b busy=%b required 1 0", in_ready[0], busy[0]);
        end
    endtask

    task automatic test_forward();
        logic [127:0] res;
        int lat;
        run_block(0, C_PLAIN, 1'b0, res, lat);
        n_cmp++;
        if (res !== C_MIXED) begin
            n_fail++;
            $display("FAIL fwd_c1: got %h required %h", res, C_MIXED);
        end
        n_cmp++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL fwd_c1_latency: got %0d required 4", lat);
        end
        run_block(1, C_PLAIN, 1'b0, res, lat);
        n_cmp++;
        if (res !== C_MIXED || lat != 2) begin
            n_fail++;
            $display("FAIL fwd_c2: got %h lat %0d required %h lat 2", res, lat, C_MIXED);
        end
    endtask

    task automatic test_inverse();
        logic [127:0] res;
        int lat;
        run_block(0, C_MIXED, 1'b1, res, lat);
        n_cmp++;
        if (res !== C_PLAIN || lat != 4) begin
            n_fail++;
            $display("FAIL inv_c1: got %h lat %0d required %h lat 4", res, lat, C_PLAIN);
        end
        run_block(2, C_MIXED, 1'b1, res, lat);
        n_cmp++;
        if (res !== C_PLAIN || lat != 1) begin
            n_fail++;
            $display("FAIL inv_c4: got %h lat %0d required %h lat 1", res, lat, C_PLAIN);
        end
    endtask

    task automatic test_fixed_points();
        logic [127:0] res;
        int lat;
        run_block(1, C_FP_IN, 1'b0, res, lat);
        n_cmp++;
        if (res !== C_FP_OUT) begin
            n_fail++;
            $display("FAIL fixed_fwd: got %h required %h", res, C_FP_OUT);
        end
        run_block(1, C_FP_OUT, 1'b1, res, lat);
        n_cmp++;
        if (res !== C_FP_IN) begin
            n_fail++;
            $display("FAIL fixed_inv: got %h required %h", res, C_FP_IN);
        end
        run_block(2, C_FP_IN, 1'b0, res, lat);
        n_cmp++;
        if (res !== C_FP_OUT) begin
            n_fail++;
            $display("FAIL fixed_fwd_c4: got %h required %h", res, C_FP_OUT);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        in_valid[0] = 1'b1;
        state_in[0] = C_MIXED;
        inv[0]      = 1'b1;
        @(posedge clk); #1;
        guard = 0;
        while (!out_valid[0] && guard < 20) begin
            state_in[0] = {4{32'(guard) * 32'h01010101}};
            inv[0]      = guard[0];
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || state_out[0] !== C_PLAIN) begin
                n_fail++;
                $display("FAIL stall_%0d: vld=%b rdy=%b out=%h required 1 0 %h",
                         i, out_valid[0], in_ready[0], state_out[0], C_PLAIN);
            end
            state_in[0] = {4{32'(i) * 32'h11111111}};
            inv[0]      = ~inv[0];
            @(posedge clk); #1;
        end
        state_in[0]  = C_PLAIN;
        inv[0]       = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        n_cmp++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL after_handshake: rdy=%b vld=%b required 1 0", in_ready[0], out_valid[0]);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL next_accept: busy=%b rdy=%b required 1 0", busy[0], in_ready[0]);
        end
        guard = 0;
        while (!out_valid[0] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (state_out[0] !== C_MIXED || guard != 4) begin
            n_fail++;
            $display("FAIL next_block: got %h after %0d edges required %h after 4",
                     state_out[0], guard, C_MIXED);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] res;
        int lat;
        in_valid[0] = 1'b1;
        state_in[0] = C_PLAIN;
        inv[0]      = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0
            || state_out[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b busy=%b out=%h required 1 0 0 0",
                     in_ready[0], out_valid[0], busy[0], state_out[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle_%0d: vld=%b busy=%b required 0 0",
                         i, out_valid[0], busy[0]);
            end
        end
        run_block(0, C_PLAIN, 1'b0, res, lat);
        n_cmp++;
        if (res !== C_MIXED || lat != 4) begin
            n_fail++;
            $display("FAIL post_reset_block: got %h lat %0d required %h lat 4", res, lat, C_MIXED);
        end
    endtask

    task automatic test_inv_disabled();
        logic [127:0] res;
        int lat;
        run_block(3, C_PLAIN, 1'b1, res, lat);
        n_cmp++;
        if (res !== C_MIXED || lat != 4) begin
            n_fail++;
            $display("FAIL inv_disabled: got %h lat %0d required %h lat 4", res, lat, C_MIXED);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] data;
        logic [127:0] fwd;
        logic [127:0] back;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            run_block(i % 3, data, 1'b0, fwd, lat);
            run_block(i % 3, fwd, 1'b1, back, lat);
            n_cmp++;
            if (back !== data) begin
                n_fail++;
                $display("FAIL round_trip_%0d dut%0d: got %h required %h", i, i % 3, back, data);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 4; d++) begin
            in_valid[d]  = 1'b0;
            inv[d]       = 1'b0;
            out_ready[d] = 1'b0;
            state_in[d]  = 128'h0;
        end
        test_reset();
        test_forward();
        test_inverse();
        test_fixed_points();
        test_back_to_back();
        test_reset_mid_run();
        test_inv_disabled();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
